// File: rtl/float_to_int_converter.sv
// -----------------------------------------------------------------------------
// float_to_int_converter
//
// Purpose:
//   Converts the 13-bit float produced by int_to_float_converter back into an
//   8-bit two's-complement integer. Float value = (-1)^s * f * 2^(e-8), with
//   s = float_i[12], e = float_i[11:8] (unsigned), f = float_i[7:0].
//   The significand is shifted right one bit per cycle (truncation toward
//   zero); out-of-range results saturate to 127 / -128 and raise ovf_o.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. ready_o is high only in IDLE, valid_o is
//   high only in DONE; both are decoded from state alone, so neither depends
//   combinationally on valid_i or ready_i. int_o/ovf_o change only on the
//   edge that enters DONE and hold their value until the next result.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous, active-high reset
//   float_i  in  13  float operand, sampled on the accept edge
//   valid_i  in   1  upstream has an operand
//   ready_o  out  1  block can accept (IDLE only)
//   int_o    out  8  signed result, registered
//   ovf_o    out  1  result was saturated
//   valid_o  out  1  result available (DONE only)
//   ready_i  in   1  downstream consumes the result
// -----------------------------------------------------------------------------
module float_to_int_converter (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] float_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [7:0]  int_o,
   output logic        ovf_o,
   output logic        valid_o,
   input  logic        ready_i
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      state_q;
   logic        sign_q;
   logic [3:0]  count_q;
   logic [7:0]  mag_q;
   logic [7:0]  int_q;
   logic        ovf_q;

   // Operand fields
   logic        in_sign;
   logic [3:0]  in_exp;
   logic [7:0]  in_frac;

   assign in_sign = float_i[12];
   assign in_exp  = float_i[11:8];
   assign in_frac = float_i[7:0];

   // Combinational helpers feeding the registers
   logic [7:0]  mag_shift_d;
   logic [8:0]  conv_in_d;     // {ovf, int} for e == 8 straight from the operand
   logic [8:0]  conv_shift_d;  // {ovf, int} for the last shift step

   // Final conversion of an unsigned magnitude with sign to {ovf, int8}.
   // For a negative sign, m == 128 maps exactly to -128 without overflow.
   function automatic logic [8:0] final_conv(input logic s, input logic [7:0] m);
      logic [8:0] r;
      if (!s) begin
         if (m > 8'd127) r = {1'b1, 8'h7F};
         else            r = {1'b0, m};
      end else begin
         if (m > 8'd128) r = {1'b1, 8'h80};
         else            r = {1'b0, 8'd0 - m};
      end
      return r;
   endfunction

   assign mag_shift_d  = mag_q >> 1;
   assign conv_in_d    = final_conv(in_sign, in_frac);
   assign conv_shift_d = final_conv(sign_q, mag_shift_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sign_q  <= 1'b0;
         count_q <= 4'd0;
         mag_q   <= 8'd0;
         int_q   <= 8'd0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_i) begin
                  sign_q  <= in_sign;
                  mag_q   <= in_frac;
                  // Remaining shifts; only meaningful when e < 8
                  count_q <= (in_exp < 4'd8) ? (4'd8 - in_exp) : 4'd0;
                  if (in_frac == 8'd0) begin
                     // Zero ignores sign and exponent: no negative zero
                     int_q   <= 8'd0;
                     ovf_q   <= 1'b0;
                     state_q <= ST_DONE;
                  end else if (in_exp > 4'd8) begin
                     int_q   <= in_sign ? 8'h80 : 8'h7F;
                     ovf_q   <= 1'b1;
                     state_q <= ST_DONE;
                  end else if (in_exp == 4'd8) begin
                     {ovf_q, int_q} <= conv_in_d;
                     state_q        <= ST_DONE;
                  end else begin
                     state_q <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               mag_q   <= mag_shift_d;
               count_q <= count_q - 4'd1;
               // Last shift: convert the already-shifted magnitude directly
               if (count_q == 4'd1) begin
                  {ovf_q, int_q} <= conv_shift_d;
                  state_q        <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (ready_i) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ready_o = (state_q == ST_IDLE);
   assign valid_o = (state_q == ST_DONE);
   assign int_o   = int_q;
   assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_float_to_int_converter.sv
// -----------------------------------------------------------------------------
// tb_float_to_int_converter
//
// Directed vectors with hand-computed results, a backpressure sequence, a
// reset-mid-conversion sequence, and a full int8 round trip using a local
// int-to-float encoder. Expected {accept cycle, latency, ovf, int} entries are
// queued at the accept edge; a monitor pops one per rising valid_o.
// -----------------------------------------------------------------------------
module tb_float_to_int_converter;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] float_i = 13'd0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [7:0]  int_o;
  logic        ovf_o;
  logic        valid_o;
  logic        ready_i = 1'b1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  float_to_int_converter dut (
    .clk     (clk),
    .rst     (rst),
    .float_i (float_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .int_o   (int_o),
    .ovf_o   (ovf_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  // ---------------------------------------------------------------- scoreboard
  // entry = {accept_cycle[15:0], latency[3:0], ovf, int[7:0]}
  logic [28:0] exp_q[$];
  int total = 0;
  int bad = 0;
  bit in_flight = 1'b0;
  bit prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares one result per rising valid_o
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (in_flight) chk("ready_low_busy", ready_o, 0);
      chk("ready_valid_excl", ready_o & valid_o, 0);
      if (valid_o && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got int=%0h ovf=%0b expected no result", int_o, ovf_o);
        end else begin
          logic [28:0] e;
          logic [15:0] lat_act;
          e = exp_q.pop_front();
          lat_act = 16'(cyc) - e[28:13] + 16'd1;
          chk("int_o", int_o, e[7:0]);
          chk("ovf_o", ovf_o, e[8]);
          chk("latency", lat_act, 16'(e[12:9]));
        end
        in_flight = 1'b0;
      end
      prev_valid = valid_o;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send(input logic [12:0] f, input logic [7:0] ei, input logic eo,
                      input int lat, input bit push);
    int n;
    @(negedge clk);
    float_i = f;
    valid_i = 1'b1;
    n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready_o=0 expected 1");
      valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    in_flight = 1'b1;
    if (push) exp_q.push_back({16'(cyc), 4'(lat), eo, ei});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || in_flight); i++) @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  // int8 -> float encoding (normalized, e = msb position + 1)
  function automatic logic [12:0] enc(input int v);
    int m, p;
    logic s;
    logic [7:0] f;
    logic [3:0] e;
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 13'd0;
    p = 0;
    for (int b = 0; b < 8; b++) if (m >= (1 << b)) p = b;
    f = 8'(m << (7 - p));
    e = 4'(p + 1);
    return {s, e, f};
  endfunction

  function automatic int lat_of(input logic [12:0] f);
    if (f[7:0] == 8'd0 || f[11:8] >= 4'd8) return 1;
    return (8 - int'(f[11:8])) + 1;
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    #1;
    chk("rst_ready_o", ready_o, 1);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_int_o", int_o, 0);
    chk("rst_ovf_o", ovf_o, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    send(13'b0_0001_10000000, 8'h01, 1'b0, 8, 1'b1);  // 1
    send(13'b1_1000_10000000, 8'h80, 1'b0, 1, 1'b1);  // -128 exact
    send(13'b0_1000_10000000, 8'h7F, 1'b1, 1, 1'b1);  // +128 saturates
    send(13'b1_1111_11111111, 8'h80, 1'b1, 1, 1'b1);  // huge negative
    send(13'b0_0010_11100000, 8'h03, 1'b0, 7, 1'b1);  // 3.5 -> 3
    send(13'b1_0011_10110000, 8'hFB, 1'b0, 6, 1'b1);  // -5.5 -> -5
    send(13'b0_0000_11111111, 8'h00, 1'b0, 9, 1'b1);  // <1 -> 0
    send(13'b1_0101_00000000, 8'h00, 1'b0, 1, 1'b1);  // zero, sign ignored
    send(13'b0_0111_00000110, 8'h03, 1'b0, 2, 1'b1);  // unnormalized 6/2
    send(13'b0_1000_01111111, 8'h7F, 1'b0, 1, 1'b1);  // 127 exact
    send(13'b1_1001_00000001, 8'h80, 1'b1, 1, 1'b1);  // e>8 saturates
    send(13'b1_1000_10000001, 8'h80, 1'b1, 1, 1'b1);  // -129 saturates
    wait_drain();

    // Backpressure: result 192/16 = 12 held while ready_i=0
    ready_i = 1'b0;
    send(13'b0_0100_11000000, 8'h0C, 1'b0, 5, 1'b1);
    begin
      int n;
      n = 0;
      while (!valid_o && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_valid_seen", valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      float_i = 13'h0155 + 13'(i * 37);
      chk("bp_valid_hold", valid_o, 1);
      chk("bp_int_hold", int_o, 8'h0C);
      chk("bp_ovf_hold", ovf_o, 0);
      chk("bp_ready_low", ready_o, 0);
    end
    @(negedge clk);
    ready_i = 1'b1;  // valid_i still high: must not be accepted on this edge
    @(negedge clk);
    chk("bp_ready_back", ready_o, 1);
    chk("bp_valid_drop", valid_o, 0);
    valid_i = 1'b0;
    wait_drain();

    // Reset mid-SHIFT: in-flight result of 1 must never appear
    send(13'b0_0001_10000000, 8'h01, 1'b0, 8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready_o", ready_o, 1);
    chk("mid_rst_valid_o", valid_o, 0);
    chk("mid_rst_int_o", int_o, 0);
    chk("mid_rst_ovf_o", ovf_o, 0);
    in_flight = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send(13'b0_0110_10100000, 8'd40, 1'b0, 3, 1'b1);
    wait_drain();

    // Round trip over every int8 value
    for (int v = -128; v < 128; v++) begin
      logic [12:0] f;
      f = enc(v);
      send(f, 8'(v), 1'b0, lat_of(f), 1'b1);
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_to_int_converter.md
# float_to_int_converter

Multi-cycle converter from the 13-bit floating-point format produced by `int_to_float_converter` back to an 8-bit two's-complement integer. It sits directly downstream of that converter and closes the int→float→int loop in the conversion datapath. The significand is right-shifted one bit per cycle, with truncation toward zero and saturation on overflow. A valid/ready handshake is used on both the input and output sides.

## Interface
- No parameters. Formats are fixed:
  - Input float: [12] sign, [11:8] unsigned exponent e, [7:0] significand f. Value = (-1)^s · f · 2^(e-8).
  - Output: 8-bit signed integer.
- Clock and reset: one clock; reset is asynchronous and active-high.
- Ports:
  - `clk`  in  1  rising-edge clock
  - `rst`  in  1  asynchronous, active-high reset
  - `float_i`  in  13  float operand, sampled on the accept edge
  - `valid_i`  in  1  upstream has an operand
  - `ready_o`  out  1  block can accept; high only in IDLE
  - `int_o`  out  8  signed result, registered
  - `ovf_o`  out  1  result was saturated
  - `valid_o`  out  1  result available; high only in DONE
  - `ready_i`  in  1  downstream consumes the result

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `ready_o`=1.
  - On `valid_i`=1 (accept edge), register s, e, f into sign, count, mag.
  - Select the next state in priority order:
    - f==0: int_o←0, ovf_o←0, go to DONE. Sign and e are ignored, so there is no negative zero.
    - e>8: saturate and go to DONE. s=0 gives 127; s=1 gives -128. ovf_o←1.
    - e==8: apply final conversion to mag=f, go to DONE.
    - otherwise: count←8-e (1..8), go to SHIFT.
- SHIFT:
  - On each edge: mag←mag>>1, count←count-1.
  - On the edge where count==1, apply final conversion to the shifted magnitude and go to DONE.
  - `float_i` and `valid_i` are ignored.
- Final conversion, applied to 8-bit unsigned magnitude m:
  - s=0, m≤127: int_o=m, ovf_o=0.
  - s=0, m>127: int_o=127, ovf_o=1.
  - s=1, m≤128: int_o=-m (m=128 gives -128 exactly), ovf_o=0.
  - s=1, m>128: int_o=-128, ovf_o=1.
- Rounding: truncation toward zero. Shifted-out bits are discarded; there is no sticky bit and no rounding.
- Unnormalized significands (f[7]=0, f≠0) are converted arithmetically by the same formula; no error is flagged.
- DONE:
  - `valid_o`=1. `int_o` and `ovf_o` hold stable.
  - On `ready_i`=1, go to IDLE.
  - No new operand is accepted on that same edge; `ready_o` stays 0 in DONE.

## Timing
- Reset values: state=IDLE, `ready_o`=1, `valid_o`=0, `int_o`=0, `ovf_o`=0; mag and count = 0.
- Reset asserted in any state, mid-SHIFT included, aborts the conversion immediately. The in-flight result is discarded and never presented.
- Latency, accept edge to first cycle with `valid_o`=1:
  - 1 edge for f==0, e≥8.
  - (8-e)+1 edges for e≤7.
  - Worst case 9 (e=0). Best case 1.
- Throughput: one result per (latency + 1 handshake edge) minimum. The block is not pipelined; a single operand is in flight.
- `ready_o` and `valid_o` are decoded from state only. There is no combinational path from `valid_i` or `ready_i` to any output.
- `int_o` and `ovf_o` may change only on the edge entering DONE. Between conversions they retain the last result.

## Test plan
- 0_0001_10000000 (int 1):
  - `int_o`=1, `ovf_o`=0.
  - `valid_o` rises 8 edges after accept.
  - `ready_o` is low for the entire interval.
- 1_1000_10000000:
  - `int_o`=-128 (0x80), `ovf_o`=0, 1-edge latency.
  - 0_1000_10000000 gives `int_o`=127, `ovf_o`=1.
  - 1_1111_11111111 gives `int_o`=-128, `ovf_o`=1.
- Truncation:
  - 0_0010_11100000 (3.5) → 3.
  - 1_0011_10110000 (-5.5) → -5 (0xFB).
  - 0_0000_11111111 → 0 after 9 edges, `ovf_o`=0.
- Zero: 1_0101_00000000 → `int_o`=0, `ovf_o`=0, 1-edge latency.
- Backpressure:
  - Hold `ready_i`=0 for 5 cycles in DONE. `valid_o`, `int_o` and `ovf_o` stay stable.
  - `valid_i` pulses with new operands during that time are ignored.
  - After `ready_i`=1, `ready_o` returns high on the next cycle.
- Reset mid-SHIFT:
  - Accept 0_0001_10000000, then assert `rst` 3 edges later.
  - All outputs immediately return to reset values.
  - After release, 0_0110_10100000 yields `int_o`=40 with 3-edge latency.
- Exhaustive round trip: all 256 int values → `int_to_float_converter` → this block.
  - Every output equals its input with `ovf_o`=0.
